// File: rtl/test_completion_unit.sv
// End-of-test unit: watches the core's stores for a tohost write (or a tick timeout),
// then halts the core and streams the signature region out of memory port B.
module test_completion_unit #(
    parameter logic [31:0] TOHOST_ADDR = 32'h8000_1000,
    parameter int          DEPTH       = 14,
    parameter int          MAX_TICKS   = 100000
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [31:0]      dmem_addr_i,
    input  logic [3:0]       dmem_wsel_byte_i,
    input  logic [31:0]      dmem_wdata_i,
    input  logic [31:0]      sig_begin_i,
    input  logic [31:0]      sig_end_i,
    output logic             halt_o,
    output logic             mem_en_o,
    output logic [DEPTH-1:0] mem_addr_o,
    input  logic [31:0]      mem_rdata_i,
    output logic             sig_valid_o,
    output logic [31:0]      sig_data_o,
    output logic             sig_last_o,
    input  logic             sig_ready_i,
    output logic             done_o,
    output logic             pass_o,
    output logic             timeout_o,
    output logic [30:0]      fail_code_o
);

    typedef enum logic [2:0] {
        S_RUN, S_LATCH, S_READ, S_WAIT, S_OUT, S_DONE
    } state_t;

    localparam logic [31:0]      TICK_LAST = 32'(MAX_TICKS - 1);
    localparam logic [DEPTH-1:0] ONE       = DEPTH'(1);

    state_t           state;
    logic [31:0]      ticks;
    logic [DEPTH-1:0] cur;
    logic [DEPTH-1:0] last;
    logic             hit;

    // Only a full-word store with bit 0 set counts as a tohost report.
    assign hit = (dmem_wsel_byte_i == 4'hF) && (dmem_addr_i == TOHOST_ADDR) && dmem_wdata_i[0];

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state       <= S_RUN;
            ticks       <= '0;
            cur         <= '0;
            last        <= '0;
            halt_o      <= 1'b0;
            mem_en_o    <= 1'b0;
            mem_addr_o  <= '0;
            sig_valid_o <= 1'b0;
            sig_data_o  <= '0;
            sig_last_o  <= 1'b0;
            done_o      <= 1'b0;
            pass_o      <= 1'b0;
            timeout_o   <= 1'b0;
            fail_code_o <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    if (ticks != '1)
                        ticks <= ticks + 32'd1;
                    // A tohost hit on the timeout cycle takes priority.
                    if (hit) begin
                        pass_o      <= (dmem_wdata_i == 32'd1);
                        fail_code_o <= (dmem_wdata_i == 32'd1) ? '0 : dmem_wdata_i[31:1];
                        state       <= S_LATCH;
                    end else if (ticks == TICK_LAST) begin
                        timeout_o <= 1'b1;
                        state     <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    halt_o <= 1'b1;
                    cur    <= sig_begin_i[DEPTH+1:2];
                    last   <= sig_end_i[DEPTH+1:2];
                    if (sig_end_i <= sig_begin_i) begin
                        done_o <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        mem_en_o   <= 1'b1;
                        mem_addr_o <= sig_begin_i[DEPTH+1:2];
                        state      <= S_READ;
                    end
                end
                S_READ: begin
                    mem_en_o <= 1'b0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    sig_data_o  <= mem_rdata_i;
                    sig_valid_o <= 1'b1;
                    sig_last_o  <= ((cur + ONE) == last);
                    state       <= S_OUT;
                end
                S_OUT: begin
                    if (sig_ready_i) begin
                        sig_valid_o <= 1'b0;
                        sig_last_o  <= 1'b0;
                        cur         <= cur + ONE;
                        if (sig_last_o) begin
                            done_o <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            mem_en_o   <= 1'b1;
                            mem_addr_o <= cur + ONE;
                            state      <= S_READ;
                        end
                    end
                end
                S_DONE: ;
                default: state <= S_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_test_completion_unit.sv
// Randomized and directed checks of test_completion_unit against a list-level model
// of the signature region held in a behavioural memory.
module tb_test_completion_unit;

    localparam logic [31:0] TOHOST = 32'h8000_1000;
    localparam int          DEPTH  = 14;
    localparam int          NWORDS = 1 << DEPTH;
    localparam int          MAXT   = 50;

    logic             clk_i = 1'b0;
    logic             rstn_i = 1'b0;
    logic [31:0]      dmem_addr_i = '0;
    logic [3:0]       dmem_wsel_byte_i = '0;
    logic [31:0]      dmem_wdata_i = '0;
    logic [31:0]      sig_begin_i = '0;
    logic [31:0]      sig_end_i = '0;
    logic             halt_o, mem_en_o, sig_valid_o, sig_last_o, done_o, pass_o, timeout_o;
    logic [DEPTH-1:0] mem_addr_o;
    logic [31:0]      mem_rdata_i = '0;
    logic [31:0]      sig_data_o;
    logic             sig_ready_i = 1'b0;
    logic [30:0]      fail_code_o;

    test_completion_unit #(.TOHOST_ADDR(TOHOST), .DEPTH(DEPTH), .MAX_TICKS(MAXT)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .dmem_addr_i(dmem_addr_i), .dmem_wsel_byte_i(dmem_wsel_byte_i), .dmem_wdata_i(dmem_wdata_i),
        .sig_begin_i(sig_begin_i), .sig_end_i(sig_end_i),
        .halt_o(halt_o), .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i),
        .sig_valid_o(sig_valid_o), .sig_data_o(sig_data_o), .sig_last_o(sig_last_o),
        .sig_ready_i(sig_ready_i), .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o),
        .fail_code_o(fail_code_o)
    );

    always #5 clk_i = ~clk_i;

    // Port-B memory with one cycle read latency.
    logic [31:0] mem [0:NWORDS-1];
    always @(posedge clk_i)
        if (mem_en_o) mem_rdata_i <= mem[mem_addr_o];

    // Handshake monitor, sampled mid-cycle; inputs change just after the rising edge.
    logic [31:0] q_data[$];
    logic        q_last[$];
    int          q_cyc[$];
    int          cyc = 0, n_reads = 0, n_valid = 0;
    always @(negedge clk_i) begin
        cyc <= cyc + 1;
        if (mem_en_o === 1'b1) n_reads <= n_reads + 1;
        if (sig_valid_o === 1'b1) n_valid <= n_valid + 1;
        if (sig_valid_o === 1'b1 && sig_ready_i === 1'b1) begin
            q_data.push_back(sig_data_o);
            q_last.push_back(sig_last_o);
            q_cyc.push_back(cyc);
        end
    end

    int n_cmp = 0, n_err = 0;

    // Reference model: number of words in [b,e) and the i-th expected word.
    function automatic int exp_count(input logic [31:0] b, input logic [31:0] e);
        int n;
        if (e <= b) return 0;
        n = (int'(e[DEPTH+1:2]) - int'(b[DEPTH+1:2]) + NWORDS) % NWORDS;
        return (n == 0) ? NWORDS : n;
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] b, input int i);
        return mem[(int'(b[DEPTH+1:2]) + i) % NWORDS];
    endfunction

    task automatic do_reset();
        rstn_i = 1'b0;
        sig_ready_i = 1'b0;
        dmem_wsel_byte_i = '0;
        repeat (2) @(posedge clk_i);
        #1 rstn_i = 1'b1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [3:0] sel, input logic [31:0] d);
        dmem_addr_i = a; dmem_wsel_byte_i = sel; dmem_wdata_i = d;
        @(posedge clk_i);
        #1 dmem_wsel_byte_i = '0; dmem_addr_i = $urandom; dmem_wdata_i = $urandom;
    endtask

    task automatic wait_done(input int budget);
        for (int c = 0; c < budget && done_o !== 1'b1; c++) begin
            @(posedge clk_i); #1;
        end
    endtask

    task automatic test_reset();
        dmem_addr_i = TOHOST; dmem_wsel_byte_i = 4'hF; dmem_wdata_i = 32'h1;
        do_reset();
        n_cmp++;
        if ({halt_o, mem_en_o, sig_valid_o, sig_last_o, done_o, pass_o, timeout_o} !== 7'b0 ||
            mem_addr_o !== '0 || sig_data_o !== '0 || fail_code_o !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got halt=%b en=%b addr=%h v=%b d=%h l=%b done=%b pass=%b to=%b fc=%h, want all 0",
                     halt_o, mem_en_o, mem_addr_o, sig_valid_o, sig_data_o, sig_last_o, done_o, pass_o, timeout_o, fail_code_o);
        end
    endtask

    task automatic load_abcd();
        mem[12'h800] = 32'hAAAA_0001; mem[12'h801] = 32'hBBBB_0002;
        mem[12'h802] = 32'hCCCC_0003; mem[12'h803] = 32'hDDDD_0004;
        sig_begin_i = 32'h8000_2000; sig_end_i = 32'h8000_2010;
    endtask

    task automatic check_stream(input string nm, input int base, input int n);
        n_cmp++;
        if (q_data.size() - base != n) begin
            n_err++; $display("FAIL %s_count: got %0d want %0d", nm, q_data.size() - base, n);
        end else
            for (int i = 0; i < n; i++) begin
                n_cmp++;
                if (q_data[base+i] !== exp_word(sig_begin_i, i) || q_last[base+i] !== (i == n - 1)) begin
                    n_err++;
                    $display("FAIL %s_word%0d: got %h last=%b want %h last=%b", nm, i,
                             q_data[base+i], q_last[base+i], exp_word(sig_begin_i, i), i == n - 1);
                end
            end
    endtask

    task automatic test_pass();
        int base;
        do_reset(); load_abcd();
        sig_ready_i = 1'b1;
        base = q_data.size();
        bus_write(TOHOST, 4'hF, 32'h1);
        n_cmp++;
        if (halt_o !== 1'b0) begin n_err++; $display("FAIL pass_halt_latch: got %b want 0", halt_o); end
        @(posedge clk_i); #1;
        n_cmp++;
        if (halt_o !== 1'b1) begin n_err++; $display("FAIL pass_halt: got %b want 1", halt_o); end
        wait_done(100);
        check_stream("pass", base, 4);
        n_cmp++;
        if (done_o !== 1'b1 || pass_o !== 1'b1 || fail_code_o !== '0 || timeout_o !== 1'b0) begin
            n_err++; $display("FAIL pass_status: got done=%b pass=%b fc=%h to=%b want 1 1 0 0", done_o, pass_o, fail_code_o, timeout_o);
        end
        n_cmp++;
        if (q_data.size() - base == 4 && q_cyc[base+1] - q_cyc[base] != 3) begin
            n_err++; $display("FAIL pass_throughput: got %0d cycles want 3", q_cyc[base+1] - q_cyc[base]);
        end
        // Terminal: a further tohost write changes nothing.
        bus_write(TOHOST, 4'hF, 32'h7);
        repeat (3) @(posedge clk_i); #1;
        n_cmp++;
        if (pass_o !== 1'b1 || fail_code_o !== '0 || done_o !== 1'b1 || halt_o !== 1'b1) begin
            n_err++; $display("FAIL done_sticky: got pass=%b fc=%h done=%b halt=%b want 1 0 1 1", pass_o, fail_code_o, done_o, halt_o);
        end
    endtask

    task automatic test_fail_code();
        int base;
        do_reset(); load_abcd();
        sig_ready_i = 1'b1;
        base = q_data.size();
        bus_write(TOHOST, 4'hF, 32'h0000_000B);
        wait_done(100);
        check_stream("fail", base, 4);
        n_cmp++;
        if (done_o !== 1'b1 || pass_o !== 1'b0 || fail_code_o !== 31'd5) begin
            n_err++; $display("FAIL fail_status: got done=%b pass=%b fc=%0d want 1 0 5", done_o, pass_o, fail_code_o);
        end
    endtask

    task automatic test_backpressure();
        int base, r0;
        logic [31:0] d;
        do_reset(); load_abcd();
        base = q_data.size();
        bus_write(TOHOST, 4'hF, 32'h1);
        for (int w = 0; w < 4; w++) begin
            for (int c = 0; c < 20 && sig_valid_o !== 1'b1; c++) begin @(posedge clk_i); #1; end
            n_cmp++;
            if (sig_valid_o !== 1'b1) begin n_err++; $display("FAIL bp_valid%0d: got 0 want 1", w); end
            if (w == 1) begin
                d = sig_data_o; r0 = n_reads;
                repeat (7) @(posedge clk_i);
                #1;
                n_cmp++;
                if (sig_data_o !== d || sig_valid_o !== 1'b1 || n_reads != r0) begin
                    n_err++; $display("FAIL bp_stall: got d=%h v=%b reads+%0d want d=%h v=1 reads+0",
                                      sig_data_o, sig_valid_o, n_reads - r0, d);
                end
            end
            sig_ready_i = 1'b1;
            @(posedge clk_i);
            #1 sig_ready_i = 1'b0;
        end
        wait_done(20);
        check_stream("bp", base, 4);
        n_cmp++;
        if (done_o !== 1'b1) begin n_err++; $display("FAIL bp_done: got %b want 1", done_o); end
    endtask

    task automatic test_timeout();
        int v0;
        do_reset();
        sig_begin_i = 32'h8000_2000; sig_end_i = 32'h8000_2000;
        v0 = n_valid;
        repeat (MAXT - 1) @(posedge clk_i);
        #1;
        n_cmp++;
        if (timeout_o !== 1'b0) begin n_err++; $display("FAIL timeout_early: got %b want 0", timeout_o); end
        @(posedge clk_i); #1;
        n_cmp++;
        if (timeout_o !== 1'b1 || pass_o !== 1'b0) begin
            n_err++; $display("FAIL timeout_fire: got to=%b pass=%b want 1 0", timeout_o, pass_o);
        end
        wait_done(10);
        n_cmp++;
        if (done_o !== 1'b1 || n_valid != v0) begin
            n_err++; $display("FAIL timeout_done: got done=%b valids=%0d want 1 0", done_o, n_valid - v0);
        end
    endtask

    task automatic test_collision();
        do_reset();
        sig_begin_i = 32'h8000_2000; sig_end_i = 32'h8000_2000;
        repeat (MAXT - 1) @(posedge clk_i);
        #1 bus_write(TOHOST, 4'hF, 32'h1);
        n_cmp++;
        if (timeout_o !== 1'b0 || pass_o !== 1'b1) begin
            n_err++; $display("FAIL collision: got to=%b pass=%b want 0 1", timeout_o, pass_o);
        end
    endtask

    task automatic test_ignored_empty();
        int v0;
        do_reset();
        sig_begin_i = 32'h8000_2040; sig_end_i = 32'h8000_2040;
        v0 = n_valid;
        bus_write(TOHOST, 4'h1, 32'h1);
        bus_write(TOHOST, 4'hF, 32'h2);
        bus_write(TOHOST + 32'd4, 4'hF, 32'h1);
        repeat (3) @(posedge clk_i); #1;
        n_cmp++;
        if (halt_o !== 1'b0 || done_o !== 1'b0 || pass_o !== 1'b0) begin
            n_err++; $display("FAIL ignored_writes: got halt=%b done=%b pass=%b want 0 0 0", halt_o, done_o, pass_o);
        end
        bus_write(TOHOST, 4'hF, 32'h1);
        wait_done(10);
        n_cmp++;
        if (done_o !== 1'b1 || pass_o !== 1'b1 || n_valid != v0 || halt_o !== 1'b1) begin
            n_err++; $display("FAIL empty_region: got done=%b pass=%b valids=%0d halt=%b want 1 1 0 1",
                              done_o, pass_o, n_valid - v0, halt_o);
        end
    endtask

    task automatic test_reset_mid_dump();
        int base;
        do_reset(); load_abcd();
        bus_write(TOHOST, 4'hF, 32'h1);
        for (int w = 0; w < 2; w++) begin
            for (int c = 0; c < 20 && sig_valid_o !== 1'b1; c++) begin @(posedge clk_i); #1; end
            if (w == 0) begin
                sig_ready_i = 1'b1;
                @(posedge clk_i);
                #1 sig_ready_i = 1'b0;
            end
        end
        rstn_i = 1'b0;
        @(posedge clk_i); #1;
        n_cmp++;
        if ({halt_o, mem_en_o, sig_valid_o, sig_last_o, done_o, pass_o, timeout_o} !== 7'b0 ||
            mem_addr_o !== '0 || sig_data_o !== '0 || fail_code_o !== '0) begin
            n_err++;
            $display("FAIL mid_reset: got halt=%b en=%b addr=%h v=%b d=%h l=%b done=%b pass=%b to=%b fc=%h, want all 0",
                     halt_o, mem_en_o, mem_addr_o, sig_valid_o, sig_data_o, sig_last_o, done_o, pass_o, timeout_o, fail_code_o);
        end
        rstn_i = 1'b1;
        sig_ready_i = 1'b1;
        base = q_data.size();
        bus_write(TOHOST, 4'hF, 32'h1);
        wait_done(100);
        check_stream("rerun", base, 4);
    endtask

    task automatic test_random();
        int base, n, w;
        logic [31:0] data;
        for (int it = 0; it < 8; it++) begin
            do_reset();
            w = $urandom_range(0, NWORDS - 1);
            n = $urandom_range(1, 7);
            sig_begin_i = 32'h8000_0000 | (32'(w) << 2);
            sig_end_i   = sig_begin_i + 32'(n * 4);
            for (int i = 0; i < n; i++) mem[(w + i) % NWORDS] = $urandom;
            data = ($urandom_range(0, 1) == 1) ? 32'h1 : ($urandom | 32'h3);
            base = q_data.size();
            repeat ($urandom_range(0, 20)) @(posedge clk_i);
            #1 bus_write(TOHOST, 4'hF, data);
            for (int c = 0; c < 400 && done_o !== 1'b1; c++) begin
                @(posedge clk_i);
                #1 sig_ready_i = 1'($urandom_range(0, 1));
            end
            check_stream("rand", base, exp_count(sig_begin_i, sig_end_i));
            n_cmp++;
            if (done_o !== 1'b1 || pass_o !== (data == 32'h1) || timeout_o !== 1'b0 ||
                fail_code_o !== ((data == 32'h1) ? 31'd0 : data[31:1])) begin
                n_err++;
                $display("FAIL rand_status%0d: got done=%b pass=%b to=%b fc=%h for tohost=%h", it,
                         done_o, pass_o, timeout_o, fail_code_o, data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail_code();
        test_backpressure();
        test_timeout();
        test_collision();
        test_ignored_empty();
        test_reset_mid_dump();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
